// File: rtl/spi_single_clk_pkg.sv
// Shared types and constants for the oversampled SPI mode-0 slave.
package spi_single_clk_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CTR_W  = 6;

   typedef logic [2:0] bit_ctr_t;

   localparam bit_ctr_t         BIT_LAST      = 3'd7;
   localparam logic [BYTE_W-1:0] TX_RESET_BYTE = 8'h00;

   typedef enum logic {
      RX_ADDR = 1'b0,
      RX_DATA = 1'b1
   } rx_kind_e;

endpackage

// File: rtl/spi_pad_sync.sv
// Two-flop synchronizer for one SPI pad, with edge detect against a delayed copy
// of the synchronized level.
module spi_pad_sync #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic pad_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
         prev_q <= RESET_VAL;
      end else begin
         meta_q <= pad_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~prev_q;
   assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_single_clk_slave.sv
// SPI mode-0 slave sampled entirely in the sys_clk domain; first byte is the address.
// Optional: define SPI_MISO_TRISTATE_EN to float miso_pad while deselected or in reset.
module spi_single_clk_slave
   import spi_single_clk_pkg::*;
#(
   parameter int unsigned BYTE_W = spi_single_clk_pkg::BYTE_W,
   parameter int unsigned CTR_W  = spi_single_clk_pkg::CTR_W
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              csn_pad,
   input  logic              sck_pad,
   input  logic              mosi_pad,
   output logic              miso_pad,
   output logic              spi_dreq,
   input  logic              spi_data_written,
   input  logic [BYTE_W-1:0] spi_data_to_send,
   output logic [BYTE_W-1:0] spi_address_rx,
   output logic              spi_address_rx_valid,
   output logic [BYTE_W-1:0] spi_data_byte_rx,
   output logic              spi_data_byte_rx_valid,
   output logic              valid_read,
   output logic [CTR_W-1:0]  byte_ctr
);

   logic csn_sync;
   logic csn_rise;
   logic csn_fall;
   logic sck_sync;
   logic sck_rise;
   logic sck_fall;
   logic mosi_sync;
   logic mosi_rise;
   logic mosi_fall;
   logic unused_sync;

   spi_pad_sync #(.RESET_VAL(1'b1)) u_csn_sync (
      .clk_i   (sys_clk),
      .rst_n_i (sys_rst_n),
      .pad_i   (csn_pad),
      .sync_o  (csn_sync),
      .rise_o  (csn_rise),
      .fall_o  (csn_fall)
   );

   spi_pad_sync #(.RESET_VAL(1'b0)) u_sck_sync (
      .clk_i   (sys_clk),
      .rst_n_i (sys_rst_n),
      .pad_i   (sck_pad),
      .sync_o  (sck_sync),
      .rise_o  (sck_rise),
      .fall_o  (sck_fall)
   );

   spi_pad_sync #(.RESET_VAL(1'b0)) u_mosi_sync (
      .clk_i   (sys_clk),
      .rst_n_i (sys_rst_n),
      .pad_i   (mosi_pad),
      .sync_o  (mosi_sync),
      .rise_o  (mosi_rise),
      .fall_o  (mosi_fall)
   );

   assign unused_sync = ^{csn_rise, sck_sync, mosi_rise, mosi_fall};

   bit_ctr_t          bit_cnt_q,     bit_cnt_d;
   logic              byte_done_q,   byte_done_d;
   logic [BYTE_W-1:0] rx_shift_q,    rx_shift_d;
   logic [BYTE_W-1:0] tx_shift_q,    tx_shift_d;
   logic [BYTE_W-1:0] tx_buf_q,      tx_buf_d;
   logic [BYTE_W-1:0] addr_q,        addr_d;
   logic              addr_valid_q,  addr_valid_d;
   logic [BYTE_W-1:0] data_q,        data_d;
   logic              data_valid_q,  data_valid_d;
   logic              valid_read_q,  valid_read_d;
   logic [CTR_W-1:0]  byte_ctr_q,    byte_ctr_d;
   logic              dreq_q,        dreq_d;
   rx_kind_e          rx_kind;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         bit_cnt_q    <= '0;
         byte_done_q  <= 1'b0;
         rx_shift_q   <= '0;
         tx_shift_q   <= '0;
         tx_buf_q     <= BYTE_W'(TX_RESET_BYTE);
         addr_q       <= '0;
         addr_valid_q <= 1'b0;
         data_q       <= '0;
         data_valid_q <= 1'b0;
         valid_read_q <= 1'b0;
         byte_ctr_q   <= '0;
         dreq_q       <= 1'b0;
      end else begin
         bit_cnt_q    <= bit_cnt_d;
         byte_done_q  <= byte_done_d;
         rx_shift_q   <= rx_shift_d;
         tx_shift_q   <= tx_shift_d;
         tx_buf_q     <= tx_buf_d;
         addr_q       <= addr_d;
         addr_valid_q <= addr_valid_d;
         data_q       <= data_d;
         data_valid_q <= data_valid_d;
         valid_read_q <= valid_read_d;
         byte_ctr_q   <= byte_ctr_d;
         dreq_q       <= dreq_d;
      end
   end

   always_comb begin
      rx_kind = (byte_ctr_q == '0) ? RX_ADDR : RX_DATA;
   end

   // The 3-bit counter wraps to 0 on the eighth rise; the completed byte is
   // committed one cycle later from byte_done_q, once rx_shift_q holds it.
   always_comb begin
      bit_cnt_d    = bit_cnt_q;
      byte_done_d  = 1'b0;
      rx_shift_d   = rx_shift_q;
      tx_shift_d   = tx_shift_q;
      tx_buf_d     = spi_data_written ? spi_data_to_send : tx_buf_q;
      addr_d       = addr_q;
      addr_valid_d = addr_valid_q;
      data_d       = data_q;
      data_valid_d = 1'b0;
      valid_read_d = valid_read_q;
      byte_ctr_d   = byte_ctr_q;
      dreq_d       = 1'b0;

      if (csn_sync) begin
         bit_cnt_d    = '0;
         byte_ctr_d   = '0;
         valid_read_d = 1'b0;
         addr_valid_d = 1'b0;
      end else begin
         if (csn_fall) begin
            valid_read_d = 1'b1;
            tx_shift_d   = tx_buf_q;
         end

         if (sck_rise) begin
            rx_shift_d  = {rx_shift_q[BYTE_W-2:0], mosi_sync};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_done_d = (bit_cnt_q == BIT_LAST);
            if (bit_cnt_q == '0) begin
               valid_read_d = 1'b0;
               dreq_d       = 1'b1;
            end
         end

         if (sck_fall && (bit_cnt_q != '0)) begin
            tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
         end

         // Loading from tx_buf_q (not tx_buf_d) makes a coincident strobe land one byte later.
         if (byte_done_q) begin
            unique case (rx_kind)
               RX_ADDR: begin
                  addr_d       = rx_shift_q;
                  addr_valid_d = 1'b1;
               end
               RX_DATA: begin
                  data_d       = rx_shift_q;
                  data_valid_d = 1'b1;
               end
               default: ;
            endcase
            if (byte_ctr_q != '1) begin
               byte_ctr_d = byte_ctr_q + 1'b1;
            end
            if (!sck_rise) begin
               bit_cnt_d = '0;
            end
            valid_read_d = 1'b1;
            tx_shift_d   = tx_buf_q;
         end
      end
   end

   assign spi_dreq               = dreq_q;
   assign spi_address_rx         = addr_q;
   assign spi_address_rx_valid   = addr_valid_q;
   assign spi_data_byte_rx       = data_q;
   assign spi_data_byte_rx_valid = data_valid_q;
   assign valid_read             = valid_read_q;
   assign byte_ctr               = byte_ctr_q;

`ifdef SPI_MISO_TRISTATE_EN
   assign miso_pad = (!sys_rst_n || csn_sync) ? 1'bz : tx_shift_q[BYTE_W-1];
`else
   assign miso_pad = csn_sync ? 1'b0 : tx_shift_q[BYTE_W-1];
`endif

endmodule

// File: tb/tb_spi_single_clk_slave.sv
// Scoreboard bench for spi_single_clk_slave: host-side SPI driver, queue-based
// expectations for received bytes and MISO replies, monitors pop and compare.
module tb_spi_single_clk_slave;

   localparam int unsigned HALF = 50;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic       csn_pad;
   logic       sck_pad;
   logic       mosi_pad;
   logic       miso_pad;
   logic       spi_dreq;
   logic       spi_data_written;
   logic [7:0] spi_data_to_send;
   logic [7:0] spi_address_rx;
   logic       spi_address_rx_valid;
   logic [7:0] spi_data_byte_rx;
   logic       spi_data_byte_rx_valid;
   logic       valid_read;
   logic [5:0] byte_ctr;

   always #5 sys_clk = ~sys_clk;

   assign spi_data_written = spi_dreq;

   spi_single_clk_slave #(.BYTE_W(8), .CTR_W(6)) dut (
      .sys_clk                (sys_clk),
      .sys_rst_n              (sys_rst_n),
      .csn_pad                (csn_pad),
      .sck_pad                (sck_pad),
      .mosi_pad               (mosi_pad),
      .miso_pad               (miso_pad),
      .spi_dreq               (spi_dreq),
      .spi_data_written       (spi_data_written),
      .spi_data_to_send       (spi_data_to_send),
      .spi_address_rx         (spi_address_rx),
      .spi_address_rx_valid   (spi_address_rx_valid),
      .spi_data_byte_rx       (spi_data_byte_rx),
      .spi_data_byte_rx_valid (spi_data_byte_rx_valid),
      .valid_read             (valid_read),
      .byte_ctr               (byte_ctr)
   );

   typedef struct {
      bit          is_data;
      logic [7:0]  val;
      logic [7:0]  addr;
      int unsigned ctr;
   } rx_exp_t;

   int          total = 0;
   int          bad = 0;
   rx_exp_t     exp_q[$];
   logic [7:0]  miso_q[$];
   logic [7:0]  buf_m = 8'h00;
   logic [7:0]  cur_addr = 8'h00;
   int unsigned nbytes = 0;
   int unsigned dreq_exp = 0;
   int unsigned dreq_seen = 0;
   logic        addr_v_prev = 1'b0;
   int unsigned miso_bits = 0;
   logic [7:0]  miso_sh = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic unexpected(input string name);
      total++;
      bad++;
      $display("FAIL %s: got an event expected none at %0t", name, $time);
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_addr"},       32'(spi_address_rx), 0);
      chk({tag, "_addr_valid"}, 32'(spi_address_rx_valid), 0);
      chk({tag, "_data"},       32'(spi_data_byte_rx), 0);
      chk({tag, "_data_valid"}, 32'(spi_data_byte_rx_valid), 0);
      chk({tag, "_valid_read"}, 32'(valid_read), 0);
      chk({tag, "_byte_ctr"},   32'(byte_ctr), 0);
      chk({tag, "_dreq"},       32'(spi_dreq), 0);
`ifndef SPI_MISO_TRISTATE_EN
      chk({tag, "_miso"},       32'(miso_pad), 0);
`endif
   endtask

   // Byte n of a transaction returns whatever the parent offered at byte n-1
   // (or the buffer contents from before the transaction for byte 0).
   task automatic byte_xfer(input logic [7:0] b, input logic [7:0] resp, input int unsigned nbits);
      rx_exp_t e;
      e = '{is_data: 1'b0, val: 8'h00, addr: 8'h00, ctr: 0};
      spi_data_to_send = resp;
      dreq_exp++;
      if (nbits == 8) begin
         miso_q.push_back(buf_m);
         if (nbytes == 0) cur_addr = b;
         e.is_data = (nbytes != 0);
         e.val     = b;
         e.addr    = cur_addr;
         nbytes++;
         e.ctr     = (nbytes > 63) ? 63 : nbytes;
         exp_q.push_back(e);
      end
      buf_m = resp;
      for (int i = 0; i < int'(nbits); i++) begin
         mosi_pad = b[7-i];
         #(HALF);
         sck_pad = 1'b1;
         #(HALF);
         sck_pad = 1'b0;
         if (i == 0) chk("valid_read_in_byte", 32'(valid_read), 0);
      end
      if (nbits == 8) begin
         mosi_pad = 1'b0;
         #(2*HALF);
         chk("valid_read_gap", 32'(valid_read), 1);
         chk("byte_ctr_gap", 32'(byte_ctr), e.ctr);
         chk("addr_valid_gap", 32'(spi_address_rx_valid), 1);
      end
   endtask

   task automatic begin_trans();
      csn_pad = 1'b0;
      nbytes  = 0;
      #(2*HALF);
      chk("valid_read_csn_fall", 32'(valid_read), 1);
      chk("byte_ctr_csn_fall", 32'(byte_ctr), 0);
      chk("addr_valid_csn_fall", 32'(spi_address_rx_valid), 0);
   endtask

   task automatic end_trans();
      csn_pad = 1'b1;
      #(2*HALF);
      chk("byte_ctr_idle", 32'(byte_ctr), 0);
      chk("addr_valid_idle", 32'(spi_address_rx_valid), 0);
      chk("valid_read_idle", 32'(valid_read), 0);
`ifndef SPI_MISO_TRISTATE_EN
      chk("miso_idle", 32'(miso_pad), 0);
`endif
   endtask

   initial begin : rx_monitor
      rx_exp_t e;
      forever begin
         @(negedge sys_clk);
         if (spi_address_rx_valid && !addr_v_prev) begin
            if (exp_q.size() == 0) unexpected("addr_strobe");
            else begin
               e = exp_q.pop_front();
               chk("rx_kind_addr", 32'(e.is_data), 0);
               chk("addr_value", 32'(spi_address_rx), 32'(e.val));
               chk("addr_byte_ctr", 32'(byte_ctr), e.ctr);
            end
         end
         if (spi_data_byte_rx_valid) begin
            if (exp_q.size() == 0) unexpected("data_strobe");
            else begin
               e = exp_q.pop_front();
               chk("rx_kind_data", 32'(e.is_data), 1);
               chk("data_value", 32'(spi_data_byte_rx), 32'(e.val));
               chk("data_byte_ctr", 32'(byte_ctr), e.ctr);
               chk("addr_hold", 32'(spi_address_rx), 32'(e.addr));
               chk("addr_valid_hold", 32'(spi_address_rx_valid), 1);
            end
         end
         if (spi_dreq) dreq_seen++;
         addr_v_prev = spi_address_rx_valid;
      end
   end

   initial begin : miso_monitor
      logic [7:0] exp_b;
      forever begin
         @(posedge sck_pad or posedge csn_pad);
         if (csn_pad === 1'b1) begin
            miso_bits = 0;
         end else begin
            miso_sh = {miso_sh[6:0], miso_pad};
            miso_bits++;
            if (miso_bits == 8) begin
               miso_bits = 0;
               if (miso_q.size() == 0) unexpected("miso_byte");
               else begin
                  exp_b = miso_q.pop_front();
                  chk("miso_byte", 32'(miso_sh), 32'(exp_b));
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int unsigned n;
      sys_rst_n        = 1'b0;
      csn_pad          = 1'b1;
      sck_pad          = 1'b0;
      mosi_pad         = 1'b0;
      spi_data_to_send = 8'h00;
      repeat (5) @(negedge sys_clk);
      chk_cleared("reset");
      sys_rst_n = 1'b1;
      repeat (5) @(negedge sys_clk);
`ifndef SPI_MISO_TRISTATE_EN
      chk("miso_after_reset", 32'(miso_pad), 0);
`endif

      begin_trans();
      chk("miso_byte0_msb", 32'(miso_pad), 0);
      byte_xfer(8'h85, 8'hFF, 8);
      byte_xfer(8'h12, 8'h01, 8);
      byte_xfer(8'h34, 8'h5A, 8);
      end_trans();

      begin_trans();
      byte_xfer(8'hA5, 8'h3C, 8);
      byte_xfer(8'h96, 8'hC3, 4);
      end_trans();

      begin_trans();
      for (int k = 0; k < 70; k++) byte_xfer(8'($urandom), 8'($urandom), 8);
      chk("byte_ctr_saturated", 32'(byte_ctr), 63);
      end_trans();

      begin_trans();
      byte_xfer(8'($urandom), 8'($urandom), 8);
      byte_xfer(8'($urandom), 8'($urandom), 4);
      #1;
      sys_rst_n = 1'b0;
      #1;
      chk_cleared("midbyte_reset");
      buf_m = 8'h00;
      #8;
      csn_pad = 1'b1;
      #(2*HALF);
      sys_rst_n = 1'b1;
      #(2*HALF);
      begin_trans();
      for (int k = 0; k < 3; k++) byte_xfer(8'($urandom), 8'($urandom), 8);
      end_trans();

      for (int t = 0; t < 15; t++) begin
         begin_trans();
         n = $urandom_range(1, 6);
         for (int k = 0; k < int'(n); k++) byte_xfer(8'($urandom), 8'($urandom), 8);
         if ($urandom_range(0, 3) == 0)
            byte_xfer(8'($urandom), 8'($urandom), $urandom_range(1, 7));
         end_trans();
      end

      for (int i = 0; i < 100 && (exp_q.size() != 0 || miso_q.size() != 0); i++)
         @(negedge sys_clk);
      chk("rx_queue_drained", 32'(exp_q.size()), 0);
      chk("miso_queue_drained", 32'(miso_q.size()), 0);
      chk("dreq_count", dreq_seen, dreq_exp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_single_clk_slave.md
# spi_single_clk_slave

SPI mode-0 slave (CPOL=0, CPHA=0, MSB first) that oversamples the pad signals with the single system clock. No SCK-domain logic exists. Per chip-select transaction, the first received byte is the address and every later byte is data. The block returns a response stream that is one byte behind the host requests. It sits between the SPI pads and the register/voice control state machine.

## Interface
- `BYTE_W`, default 8: SPI word width in bits.
- `CTR_W`, default 6: width of the per-transaction byte counter.
- `sys_clk` in 1: system clock; must run at ≥ 8× SCK.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `csn_pad` in 1: chip select, active-low, asynchronous to `sys_clk`.
- `sck_pad` in 1: SPI clock, asynchronous to `sys_clk`.
- `mosi_pad` in 1: serial data in.
- `miso_pad` out 1: serial data out.
- `spi_dreq` out 1: one-cycle request for the next response byte.
- `spi_data_written` in 1: strobe that captures `spi_data_to_send` into the TX buffer. May be looped back from `spi_dreq`.
- `spi_data_to_send` in BYTE_W: response byte supplied by the parent.
- `spi_address_rx` out BYTE_W: first byte of the current transaction.
- `spi_address_rx_valid` out 1: level. High from address-byte completion until CSN deasserts.
- `spi_data_byte_rx` out BYTE_W: most recent data byte (2nd byte onward).
- `spi_data_byte_rx_valid` out 1: one-cycle pulse per completed data byte.
- `valid_read` out 1: level. High while the bus is between bytes with CSN asserted.
- `byte_ctr` out CTR_W: bytes completed in the current transaction.

## Operation
- **Synchronisation**
  - `csn_pad`, `sck_pad` and `mosi_pad` each pass through a 2-FF synchronizer.
  - SCK rise and fall are detected from synced-stage vs. previous-stage compares.
  - CSN falling is detected the same way.
- **CSN high (idle)**
  - Held at zero: bit counter, `byte_ctr`, `valid_read`, `spi_address_rx_valid`.
  - `spi_address_rx` and `spi_data_byte_rx` keep their last values.
  - SCK edges are ignored.
- **CSN falling (synced)**
  - `valid_read` goes to 1.
  - The TX shift register loads from the TX buffer.
- **SCK rising, CSN low**
  - Synced MOSI shifts into the RX shift register LSB; bit counter increments.
  - If this is the first bit of a byte: `valid_read` goes to 0 and `spi_dreq` pulses one cycle.
- **Eighth rising edge (byte complete), evaluated the cycle after the shift**
  - If `byte_ctr` is 0: `spi_address_rx` takes the byte and `spi_address_rx_valid` goes to 1.
  - Otherwise: `spi_data_byte_rx` takes the byte and `spi_data_byte_rx_valid` pulses.
  - `byte_ctr` increments, saturating at 2^CTR_W−1.
  - Bit counter returns to 0 and `valid_read` goes to 1.
  - The TX shift register loads from the TX buffer.
- **SCK falling, CSN low, bit counter ≠ 0**: the TX shift register shifts left. `miso_pad` always reflects TX shift MSB.
- **TX buffer**
  - Captures `spi_data_to_send` on any cycle `spi_data_written` is 1.
  - Reset value is 0x00.
  - Net effect: the byte captured during byte N is transmitted as byte N+1. Byte 0 returns the buffer contents from before the transaction.
- **CSN rising mid-byte**
  - The partial byte is discarded, with no valid strobe.
  - `byte_ctr` and the bit counter are cleared.
- **Simultaneous strobe and load**: when `spi_data_written` coincides with a byte-complete load, the TX shift register loads the old buffer value. The new value goes out on the following byte.

## Timing
- Pad edge to internal detection: 2–3 `sys_clk` cycles.
- Last SCK rise to `spi_data_byte_rx_valid` or `spi_address_rx_valid`: ≤ 4 cycles.
- `byte_ctr` updates on the same cycle as the valid strobe.
- `valid_read` rises on that same cycle and stays high ≥ 2 cycles whenever SCK low time ≥ 4 cycles. The parent is allowed to sample it with a 3-stage rising-edge detector.
- `spi_dreq` is exactly one cycle wide, once per byte.
- `miso_pad` changes ≤ 4 cycles after an SCK fall, CSN fall, or byte completion. It is stable before the next SCK rise given the 8× clock ratio.
- Reset values: all outputs 0, except `miso_pad`, which follows the Configuration section. Synchronizers reset to CSN=1, SCK=0.

## Configuration
- `SPI_MISO_TRISTATE_EN` defined: `miso_pad` is high-impedance while synced CSN is high, and during reset.
- Not defined: `miso_pad` is driven 0 while CSN is high.

## Structure
- Package `spi_single_clk_pkg` holds `BYTE_W`, `CTR_W`, the 3-bit bit-counter type, and constants `BIT_LAST` = 7 and `TX_RESET_BYTE` = 8'h00.
- Sub-module `spi_pad_sync` contains the 2-FF synchronizer plus rise/fall detect. It is instantiated three times.

## Test plan
- Reset, then CSN low: all outputs 0, `valid_read`=1, `byte_ctr`=0. CSN high drives `miso_pad` 0, or Z with `SPI_MISO_TRISTATE_EN`.
- Send 0x85, 0x12, 0x34 with `spi_dreq` looped to `spi_data_written`:
  - Address 0x85 with `spi_address_rx_valid` held high.
  - Two `spi_data_byte_rx_valid` pulses carrying 0x12 then 0x34.
  - `byte_ctr` steps 1, 2, 3.
- Parent drives `spi_data_to_send` = 0xFF before byte 0 and 0x01 before byte 1: MISO returns 0x00, 0xFF, 0x01.
- Raise CSN after 4 bits of byte 1: no data strobe fires. `byte_ctr`=0, `spi_address_rx_valid`=0, `valid_read`=0.
- Send 70 bytes: `byte_ctr` saturates at 63 and data strobes continue.
- Assert `sys_rst_n`=0 mid-byte: all state clears immediately. The next transaction after release is received correctly.
